// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, co, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, co, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB first,
// WIDTH cycles per operation with valid/ready handshakes on both sides.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave io
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             co_r;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fa;
  logic             last_bit;

  // Two cascaded half adders; the carry-out is the OR of both half-adder carries.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s1, c1, s2, c2;
    s1 = x ^ y;
    c1 = x & y;
    s2 = s1 ^ ci;
    c2 = s1 & ci;
    return {c1 | c2, s2};
  endfunction

  assign fa       = full_add(a_sh[0], b_sh[0], carry);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io.in_valid) state_next = RUN;
      RUN:     if (last_bit)    state_next = DONE;
      DONE:    if (io.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, one bit per RUN cycle, co latched on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      co_r  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_sh  <= io.a;
            b_sh  <= io.b;
            carry <= io.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {fa[0], res[WIDTH-1:1]};
          carry <= fa[1];
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) co_r <= fa[1];
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state == RUN);
  assign io.sum       = res;
  assign io.co        = co_r;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 against
// hand-computed values and a (a+b+cin) reference.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  serial_adder_if #(.WIDTH(W)) io ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation through both handshakes; report observed result and latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output int lat, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    while (!io.in_ready && n < 50) begin step(); n++; end
    if (!io.in_ready) to = 1'b1;
    io.in_valid = 1'b1; io.a = a; io.b = b; io.cin = c; io.out_ready = 1'b0;
    step();
    io.in_valid = 1'b0;
    lat = 0;
    while (!io.out_valid && lat < 50) begin step(); lat++; end
    if (!io.out_valid) to = 1'b1;
    s  = io.sum;
    co = io.co;
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.in_valid = 1'b1; io.a = 8'hAA; io.b = 8'h55; io.cin = 1'b1; io.out_ready = 1'b1;
    step();
    step();
    checks++;
    if ({io.in_ready, io.out_valid, io.busy, io.co} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/busy/co=%b required 1000",
               {io.in_ready, io.out_valid, io.busy, io.co});
    end
    checks++;
    if (io.sum !== 8'h00) begin
      errors++;
      $display("FAIL reset_sum: got %h required 00", io.sum);
    end
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int bad_busy = 0;
    io.a = 8'h0F; io.b = 8'h01; io.cin = 1'b0; io.in_valid = 1'b1; io.out_ready = 1'b1;
    step();
    io.in_valid = 1'b0;
    for (int i = 1; i <= W; i++) begin
      if (!(io.busy === 1'b1 && io.out_valid === 1'b0 && io.in_ready === 1'b0)) bad_busy++;
      step();
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL basic_busy: got %0d bad RUN cycles required 0", bad_busy);
    end
    checks++;
    if ({io.out_valid, io.busy, io.co, io.sum} !== {1'b1, 1'b0, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL basic_result: got vld=%b busy=%b co=%b sum=%h required vld=1 busy=0 co=0 sum=10",
               io.out_valid, io.busy, io.co, io.sum);
    end
    step();
    checks++;
    if ({io.in_ready, io.out_valid, io.sum} !== {1'b1, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL basic_idle: got rdy=%b vld=%b sum=%h required rdy=1 vld=0 sum=10",
               io.in_ready, io.out_valid, io.sum);
    end
    io.out_ready = 1'b0;
  endtask

  task automatic test_carry();
    logic [W-1:0] s;
    logic co;
    int lat;
    bit to;
    run_op(8'hFF, 8'h01, 1'b0, s, co, lat, to);
    checks++;
    if ({to, co, s} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL carry_ff_01: got to=%b co=%b sum=%h required to=0 co=1 sum=00", to, co, s);
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL carry_latency: got %0d required %0d", lat, W);
    end
    run_op(8'hFF, 8'hFF, 1'b1, s, co, lat, to);
    checks++;
    if ({to, co, s} !== {1'b0, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL carry_ff_ff_1: got to=%b co=%b sum=%h required to=0 co=1 sum=ff", to, co, s);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int unstable = 0;
    io.a = 8'h3C; io.b = 8'h5A; io.cin = 1'b1; io.in_valid = 1'b1; io.out_ready = 1'b0;
    step();
    io.in_valid = 1'b0;
    while (!io.out_valid && n < 50) begin step(); n++; end
    io.in_valid = 1'b1; io.a = 8'h01; io.b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!(io.out_valid === 1'b1 && io.in_ready === 1'b0 && io.sum === 8'h97 && io.co === 1'b0))
        unstable++;
    end
    checks++;
    if (unstable != 0 || n != W) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d unstable cycles latency %0d required 0 and %0d",
               unstable, n, W);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    checks++;
    if ({io.in_ready, io.out_valid, io.sum} !== {1'b1, 1'b0, 8'h97}) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b sum=%h required rdy=1 vld=0 sum=97",
               io.in_ready, io.out_valid, io.sum);
    end
  endtask

  task automatic test_hold_inputs();
    int n = 0;
    int extra = 0;
    io.a = 8'h21; io.b = 8'h13; io.cin = 1'b0; io.in_valid = 1'b1; io.out_ready = 1'b0;
    step();
    while (!io.out_valid && n < 50) begin
      io.a = 8'($urandom); io.b = 8'($urandom); io.cin = 1'($urandom);
      if (io.in_ready) extra++;
      step();
      n++;
    end
    checks++;
    if ({io.out_valid, io.co, io.sum} !== {1'b1, 1'b0, 8'h34} || extra != 0) begin
      errors++;
      $display("FAIL hold_inputs: got vld=%b co=%b sum=%h ready_seen=%0d required vld=1 co=0 sum=34 ready_seen=0",
               io.out_valid, io.co, io.sum, extra);
    end
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    checks++;
    if ({io.in_ready, io.busy} !== 2'b10) begin
      errors++;
      $display("FAIL hold_handshake: got rdy=%b busy=%b required rdy=1 busy=0", io.in_ready, io.busy);
    end
    io.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_in_run();
    logic [W-1:0] s;
    logic co;
    int lat;
    bit to;
    int seen = 0;
    io.a = 8'hF0; io.b = 8'h0F; io.cin = 1'b1; io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({io.in_ready, io.out_valid, io.busy, io.co, io.sum} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL reset_run_state: got rdy=%b vld=%b busy=%b co=%b sum=%h required 1 0 0 0 00",
               io.in_ready, io.out_valid, io.busy, io.co, io.sum);
    end
    for (int i = 0; i < 12; i++) begin
      if (io.out_valid) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_run_no_valid: got %0d out_valid cycles required 0", seen);
    end
    run_op(8'h12, 8'h34, 1'b0, s, co, lat, to);
    checks++;
    if ({to, co, s} !== {1'b0, 1'b0, 8'h46}) begin
      errors++;
      $display("FAIL reset_run_fresh: got to=%b co=%b sum=%h required to=0 co=0 sum=46", to, co, s);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      logic [W:0] exp;
      int n;
      bit done;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      repeat ($urandom_range(0, 2)) step();
      io.a = ra; io.b = rb; io.cin = rc; io.in_valid = 1'b1;
      io.out_ready = 1'($urandom);
      step();
      io.in_valid = 1'($urandom);
      io.a = 8'($urandom); io.b = 8'($urandom);
      n = 0;
      while (!io.out_valid && n < 50) begin
        io.out_ready = 1'($urandom);
        step();
        n++;
      end
      checks++;
      if (!io.out_valid || {io.co, io.sum} !== exp || n != W) begin
        errors++;
        $display("FAIL random_%0d: got vld=%b co=%b sum=%h lat=%0d required co=%b sum=%h lat=%0d",
                 k, io.out_valid, io.co, io.sum, n, exp[W], exp[W-1:0], W);
      end
      done = 1'b0;
      n = 0;
      while (!done && n < 20) begin
        io.out_ready = 1'($urandom);
        io.in_valid = 1'b0;
        if (io.out_ready) done = 1'b1;
        step();
        n++;
      end
      if (!done) begin
        io.out_ready = 1'b1;
        step();
      end
      io.out_ready = 1'b0;
      io.in_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0; io.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_hold_inputs();
    test_reset_in_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (WIDTH >= 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  operand set a/b/cin is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum/co hold a completed result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-012 co  output  1  carry-out of the WIDTH-bit addition.
REQ-013 busy  output  1  high while in RUN.

Function
REQ-014 Architecture: one bit-serial full-adder cell (two half-adder stages plus OR of carries) and one carry flip-flop; LSB first; no parallel WIDTH-bit adder.
REQ-015 FSM states: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-017 Accept: in_valid & in_ready at an edge -> capture a, b into shift registers, carry FF <= cin, bit counter <= 0, go to RUN.
REQ-018 RUN: each cycle s = a_sh[0]^b_sh[0]^c; c_next = majority(a_sh[0], b_sh[0], c); s shifts into result MSB, result shifts right; a_sh, b_sh shift right; counter increments.
REQ-019 RUN lasts exactly WIDTH cycles; at the edge processing bit WIDTH-1 go to DONE with co <= final carry.
REQ-020 Latency: out_valid rises exactly WIDTH+1 rising edges after the accepting edge counts as edge 0 (i.e. first visible in cycle WIDTH+1).
REQ-021 RUN and DONE: in_ready=0; in_valid and operand inputs ignored; no overlap of operations.
REQ-022 DONE: out_valid=1; sum and co stable and unchanged until handshake.
REQ-023 out_valid & out_ready at an edge -> IDLE; earliest next accept is the following edge.
REQ-024 out_ready while not in DONE has no effect.
REQ-025 sum and co change only in RUN/at RUN->DONE; they hold their last value in IDLE.
REQ-026 Counter width ceil(log2(WIDTH))+1; no wrap possible within one operation.
REQ-027 All arithmetic unsigned; carry beyond bit WIDTH-1 appears only on co.

Reset
REQ-028 rst=1 at an edge -> state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, co=0, carry FF=0, counter=0, shift registers=0.
REQ-029 rst overrides every other input, including in_valid & in_ready and out_valid & out_ready in the same cycle.
REQ-030 rst during RUN or DONE discards the operation; no out_valid for it after reset.
REQ-031 First accept possible at the first edge with rst=0.

Verification (WIDTH=8)
REQ-032 a=0x0F, b=0x01, cin=0, out_ready=1 -> out_valid high in cycle 9 after accept, sum=0x10, co=0, busy high cycles 1-8.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, co=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, co=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/co/out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 in_valid held high with changing a/b during RUN -> result equals captured operands only; no second accept until after output handshake.
REQ-036 rst asserted in RUN cycle 4 -> next cycle IDLE, all outputs at reset values, no out_valid; fresh op 0x12+0x34 then yields 0x46, co=0.
REQ-037 Random: 1000 random a/b/cin with random out_ready and in_valid gaps, compared against a reference model ((a+b+cin) split into sum/co).
